// File: rtl/rvfpm_result_sequencer_pkg.sv
// Shared types for the rvfpm in-order result sequencer: slot state, slot record, pointer width.
package pa_rvfpm;

    localparam int RSEQ_DEPTH = 4;
    localparam int RSEQ_ID_W  = 4;
    localparam int RSEQ_FLEN  = 32;
    localparam int RSEQ_PTR_W = $clog2(RSEQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        FREE,
        ISSUED,
        COMMITTED,
        KILLED
    } rseq_state_t;

    typedef struct packed {
        rseq_state_t            state;
        logic                   done;
        logic [RSEQ_ID_W-1:0]   id;
        logic [RSEQ_FLEN-1:0]   data;
        logic [4:0]             rd;
    } rseq_slot_t;

endpackage

// File: rtl/rvfpm_result_sequencer_cam.sv
// Combinational ID match across all sequencer slots; the lowest matching index wins.
module rvfpm_rseq_cam #(
    parameter  int DEPTH = 4,
    parameter  int ID_W  = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ID_W-1:0] ids,
    input  logic [DEPTH-1:0]           mask,
    input  logic [ID_W-1:0]            key,
    output logic                       hit,
    output logic [IDX_W-1:0]           idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i] && (ids[i] == key)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rvfpm_result_sequencer.sv
// In-order result scheduler between the FPU datapath and the XIF result port.
// Optional same-cycle completion bypass on a committed head: define RVFPM_RSEQ_BYPASS_EN.
module rvfpm_result_sequencer
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = RSEQ_DEPTH,
    parameter int X_ID_WIDTH = RSEQ_ID_W,
    parameter int FLEN       = RSEQ_FLEN
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [X_ID_WIDTH-1:0]   alloc_id,
    output logic                    alloc_ready,
    input  logic                    commit_valid,
    input  logic [X_ID_WIDTH-1:0]   commit_id,
    input  logic                    commit_kill,
    input  logic                    dp_valid,
    input  logic [X_ID_WIDTH-1:0]   dp_id,
    input  logic [FLEN-1:0]         dp_data,
    input  logic [4:0]              dp_rd,
    output logic                    dp_ready,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [X_ID_WIDTH-1:0]   result_id,
    output logic [FLEN-1:0]         result_data,
    output logic [4:0]              result_rd,
    output logic                    orphan,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    rseq_state_t             state_q [DEPTH];
    logic [DEPTH-1:0]        done_q;
    logic [X_ID_WIDTH-1:0]   id_q    [DEPTH];
    logic [FLEN-1:0]         data_q  [DEPTH];
    logic [4:0]              rd_q    [DEPTH];
    logic [PTR_W-1:0]        head_q, tail_q, count_q;
    logic                    orphan_q;

    rseq_slot_t              slot    [DEPTH];
    rseq_state_t             cm_state [DEPTH];
    logic [DEPTH-1:0][X_ID_WIDTH-1:0] cm_ids, dp_ids;
    logic [DEPTH-1:0]        cm_mask, dp_mask;
    logic                    cm_hit, dp_hit;
    logic [IDX_W-1:0]        cm_idx, dp_idx, head_idx, tail_idx;
    rseq_slot_t              head;
    logic                    alloc_fire, empty, head_killed, head_done, byp;
    logic                    retire, dp_store, cm_apply;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign alloc_ready = (count_q != PTR_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign dp_ready    = 1'b1;
    assign count       = count_q;
    assign orphan      = orphan_q;

    // Commit search sees the slot being allocated this cycle as already ISSUED.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot[i] = '{state: state_q[i], done: done_q[i], id: id_q[i],
                        data: data_q[i], rd: rd_q[i]};
            cm_state[i] = slot[i].state;
            cm_ids[i]   = slot[i].id;
            if (alloc_fire && (IDX_W'(i) == tail_idx)) begin
                cm_state[i] = ISSUED;
                cm_ids[i]   = alloc_id;
            end
            cm_mask[i] = (cm_state[i] != FREE);
            dp_ids[i]  = slot[i].id;
            dp_mask[i] = (((slot[i].state == ISSUED) || (slot[i].state == COMMITTED))
                          && !slot[i].done) || (slot[i].state == KILLED);
        end
    end

    rvfpm_rseq_cam #(.DEPTH(DEPTH), .ID_W(X_ID_WIDTH)) u_cam_commit (
        .ids  (cm_ids),
        .mask (cm_mask),
        .key  (commit_id),
        .hit  (cm_hit),
        .idx  (cm_idx)
    );

    rvfpm_rseq_cam #(.DEPTH(DEPTH), .ID_W(X_ID_WIDTH)) u_cam_dp (
        .ids  (dp_ids),
        .mask (dp_mask),
        .key  (dp_id),
        .hit  (dp_hit),
        .idx  (dp_idx)
    );

    assign head        = slot[head_idx];
    assign empty       = (head_q == tail_q);
    assign head_killed = !empty && (head.state == KILLED);
    assign head_done   = !empty && (head.state == COMMITTED) && head.done;

`ifdef RVFPM_RSEQ_BYPASS_EN
    assign byp = dp_valid && dp_hit && (dp_idx == head_idx) && !empty
                 && (head.state == COMMITTED) && !head.done;
`else
    assign byp = 1'b0;
`endif

    assign result_valid = head_done || byp;
    assign retire       = head_killed || (result_valid && result_ready);
    assign result_id    = result_valid ? head.id : '0;
    assign result_data  = byp ? dp_data : (head_done ? head.data : '0);
    assign result_rd    = byp ? dp_rd   : (head_done ? head.rd   : '0);

    // A completion that lands on a killed slot is swallowed without an orphan pulse.
    assign dp_store = dp_valid && dp_hit && (slot[dp_idx].state != KILLED);
    assign cm_apply = commit_valid && cm_hit && (cm_state[cm_idx] == ISSUED);

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (alloc_fire) begin
                state_q[tail_idx] <= ISSUED;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + 1'b1;
            end
            if (dp_store) done_q[dp_idx] <= 1'b1;
            if (cm_apply) state_q[cm_idx] <= commit_kill ? KILLED : COMMITTED;
            // Retire is last so freeing the head overrides a same-cycle bypass completion.
            if (retire) begin
                state_q[head_idx] <= FREE;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + 1'b1;
            end
            count_q  <= count_q + PTR_W'(alloc_fire) - PTR_W'(retire);
            orphan_q <= dp_valid && !dp_hit;
        end
    end

    always_ff @(posedge ck) begin
        if (alloc_fire) id_q[tail_idx] <= alloc_id;
        if (dp_store) begin
            data_q[dp_idx] <= dp_data;
            rd_q[dp_idx]   <= dp_rd;
        end
    end

endmodule

// File: tb/tb_rvfpm_result_sequencer.sv
// Directed, table-driven bench for rvfpm_result_sequencer (default build, DEPTH=4).
module tb_rvfpm_result_sequencer;

    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int FLEN  = 32;

    logic                   ck = 1'b0;
    logic                   rst = 1'b1;
    logic                   alloc_valid = 1'b0;
    logic [IDW-1:0]         alloc_id = '0;
    logic                   alloc_ready;
    logic                   commit_valid = 1'b0;
    logic [IDW-1:0]         commit_id = '0;
    logic                   commit_kill = 1'b0;
    logic                   dp_valid = 1'b0;
    logic [IDW-1:0]         dp_id = '0;
    logic [FLEN-1:0]        dp_data = '0;
    logic [4:0]             dp_rd = '0;
    logic                   dp_ready;
    logic                   result_valid;
    logic                   result_ready = 1'b0;
    logic [IDW-1:0]         result_id;
    logic [FLEN-1:0]        result_data;
    logic [4:0]             result_rd;
    logic                   orphan;
    logic [$clog2(DEPTH):0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ck = ~ck;

    rvfpm_result_sequencer #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .FLEN(FLEN)) dut (
        .ck           (ck),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_id     (alloc_id),
        .alloc_ready  (alloc_ready),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .dp_valid     (dp_valid),
        .dp_id        (dp_id),
        .dp_data      (dp_data),
        .dp_rd        (dp_rd),
        .dp_ready     (dp_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_id    (result_id),
        .result_data  (result_data),
        .result_rd    (result_rd),
        .orphan       (orphan),
        .count        (count)
    );

    typedef struct {
        logic        av;   logic [3:0]  aid;
        logic        cv;   logic [3:0]  cid;  logic kill;
        logic        dv;   logic [3:0]  did;  logic [31:0] dd; logic [4:0] drd;
        logic        rr;
        logic        e_ar; logic        e_rv; logic [3:0]  e_id;
        logic [31:0] e_data; logic [4:0] e_rd; logic e_orph; logic [2:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic av, input logic [3:0] aid,
        input logic cv, input logic [3:0] cid, input logic kill,
        input logic dv, input logic [3:0] did, input logic [31:0] dd, input logic [4:0] drd,
        input logic rr,
        input logic e_ar, input logic e_rv, input logic [3:0] e_id,
        input logic [31:0] e_data, input logic [4:0] e_rd, input logic e_orph,
        input logic [2:0] e_cnt);
        vec_t v;
        v.av = av;  v.aid = aid; v.cv = cv; v.cid = cid; v.kill = kill;
        v.dv = dv;  v.did = did; v.dd = dd; v.drd = drd; v.rr = rr;
        v.e_ar = e_ar; v.e_rv = e_rv; v.e_id = e_id; v.e_data = e_data;
        v.e_rd = e_rd; v.e_orph = e_orph; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alloc_valid  = v.av;  alloc_id  = v.aid;
        commit_valid = v.cv;  commit_id = v.cid; commit_kill = v.kill;
        dp_valid     = v.dv;  dp_id     = v.did; dp_data = v.dd; dp_rd = v.drd;
        result_ready = v.rr;
    endtask

    task automatic expect_out(input vec_t v, input string tag);
        check({tag, " alloc_ready"},  32'(alloc_ready),  32'(v.e_ar));
        check({tag, " result_valid"}, 32'(result_valid), 32'(v.e_rv));
        check({tag, " result_id"},    32'(result_id),    32'(v.e_id));
        check({tag, " result_data"},  result_data,       v.e_data);
        check({tag, " result_rd"},    32'(result_rd),    32'(v.e_rd));
        check({tag, " orphan"},       32'(orphan),       32'(v.e_orph));
        check({tag, " count"},        32'(count),        32'(v.e_cnt));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge ck);
        drive(v);
        #1;
        expect_out(v, tag);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t idle_rst;

        // Async reset asserted before the first clock edge.
        #1 rst = 1'b0;
        #1;
        idle_rst = mk(0,0, 0,0,0, 0,0,0,0, 0,  1,0,0,0,0,0,0);
        expect_out(idle_rst, "reset");
        check("reset dp_ready", 32'(dp_ready), 32'd1);
        @(negedge ck);
        rst = 1'b1;

        //            av aid cv cid k  dv did data          rd rr   ar rv id data          rd or cnt
        // Out-of-order completion, in-order commit and release.
        vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(1,2, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(1,3, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,2));
        vecs.push_back(mk(0,0, 0,0,0, 1,3,32'h1111_0003,3, 1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 0,0,0, 1,2,32'h1111_0002,2, 1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 0,0,0, 1,1,32'h1111_0001,1, 1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 1,1,0, 0,0,0,0,             1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 1,2,0, 0,0,0,0,             1,  1,1,1,32'h1111_0001,1,0,3));
        vecs.push_back(mk(0,0, 1,3,0, 0,0,0,0,             1,  1,1,2,32'h1111_0002,2,0,2));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,1,3,32'h1111_0003,3,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        // Kill 5, commit 6: only ID 6 produces a result.
        vecs.push_back(mk(1,5, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(1,6, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0, 1,5,1, 0,0,0,0,             1,  1,0,0,0,0,0,2));
        vecs.push_back(mk(0,0, 1,6,0, 0,0,0,0,             1,  1,0,0,0,0,0,2));
        vecs.push_back(mk(0,0, 0,0,0, 1,6,32'h3F80_0000,4, 1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,1,6,32'h3F80_0000,4,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        // Orphan completion, then a completion aimed at a killed slot.
        vecs.push_back(mk(0,0, 0,0,0, 1,9,32'hDEAD_BEEF,9, 1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(1,8, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0, 1,8,1, 0,0,0,0,             1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 1,8,32'hBAD0_0008,8, 1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        // Fill all slots, hold the head result under backpressure, then drain by kills.
        vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));
        vecs.push_back(mk(1,2, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(1,3, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,2));
        vecs.push_back(mk(1,4, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 1,1,0, 1,1,32'hC0DE_0001,7, 0,  0,0,0,0,0,0,4));
        vecs.push_back(mk(1,15,0,0,0, 0,0,0,0,             0,  0,1,1,32'hC0DE_0001,7,0,4));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             0,  0,1,1,32'hC0DE_0001,7,0,4));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             0,  0,1,1,32'hC0DE_0001,7,0,4));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  0,1,1,32'hC0DE_0001,7,0,4));
        vecs.push_back(mk(0,0, 1,2,1, 0,0,0,0,             1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 1,3,1, 0,0,0,0,             1,  1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0, 1,4,1, 0,0,0,0,             1,  1,0,0,0,0,0,2));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0));

        foreach (vecs[k]) apply(vecs[k], $sformatf("v%0d", k));

        // Wrap-around: alloc+commit of round r shares a cycle with retire of round r-1.
        for (int r = 0; r < 10; r++) begin
            apply(mk(1,4'(r), 1,4'(r),0, 0,0,0,0, 1,
                     1, (r > 0), (r > 0) ? 4'(r-1) : 4'd0,
                     (r > 0) ? (32'hA5A5_0000 | 32'(r-1)) : 32'd0,
                     (r > 0) ? 5'(r+9) : 5'd0, 0, (r > 0) ? 3'd1 : 3'd0),
                  $sformatf("wrap%0d-a", r));
            apply(mk(0,0, 0,0,0, 1,4'(r), 32'hA5A5_0000 | 32'(r), 5'(r+10), 1,
                     1,0,0,0,0,0,1),
                  $sformatf("wrap%0d-b", r));
        end
        apply(mk(0,0, 0,0,0, 0,0,0,0, 1,  1,1,9,32'hA5A5_0009,19,0,1), "wrap-last");
        apply(mk(0,0, 0,0,0, 0,0,0,0, 1,  1,0,0,0,0,0,0), "wrap-empty");

        // Reset while a result is being presented.
        apply(mk(1,7, 1,7,0, 0,0,0,0,             0,  1,0,0,0,0,0,0), "rst-a");
        apply(mk(0,0, 0,0,0, 1,7,32'h7777_7777,7, 0,  1,0,0,0,0,0,1), "rst-b");
        apply(mk(0,0, 0,0,0, 0,0,0,0,             0,  1,1,7,32'h7777_7777,7,0,1), "rst-c");
        #2 rst = 1'b0;
        #1 expect_out(idle_rst, "rst-mid");
        @(negedge ck);
        #1 expect_out(idle_rst, "rst-hold");
        rst = 1'b1;
        apply(mk(1,7, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0), "rst-d");
        apply(mk(0,0, 1,7,0, 0,0,0,0,             1,  1,0,0,0,0,0,1), "rst-e");
        apply(mk(0,0, 0,0,0, 1,7,32'h0000_0777,3, 1,  1,0,0,0,0,0,1), "rst-f");
        apply(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,1,7,32'h0000_0777,3,0,1), "rst-g");
        apply(mk(0,0, 0,0,0, 0,0,0,0,             1,  1,0,0,0,0,0,0), "rst-h");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfpm_result_sequencer.md
# rvfpm_result_sequencer

In-order result scheduler between the FPU datapath and the CORE-V-XIF result interface. Records every accepted writeback instruction in issue order, matches completions from the datapath and commit/kill decisions from the core against those records, and releases results on `result_*` strictly in program order, and only after commit. Killed instructions retire silently. Sits between the issue/commit front end and the result port of `rvfpm`.

## Interface
- `DEPTH`, 4: outstanding-instruction slots; power of two, ≥2.
- `X_ID_WIDTH`, 4: XIF instruction ID width.
- `FLEN`, 32: result data width.
- `ck` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: issue accepted with writeback; record `alloc_id`.
- `alloc_id` in X_ID_WIDTH: ID to record.
- `alloc_ready` out 1: a free slot exists.
- `commit_valid` in 1: commit decision.
- `commit_id` in X_ID_WIDTH: ID the decision applies to.
- `commit_kill` in 1: 1 = kill, 0 = commit.
- `dp_valid` in 1: datapath completion.
- `dp_id` in X_ID_WIDTH: completion ID.
- `dp_data` in FLEN: completion data.
- `dp_rd` in 5: completion destination register.
- `dp_ready` out 1: tied to 1; completions are never stalled.
- `result_valid` out 1: XIF result valid.
- `result_ready` in 1: XIF result ready.
- `result_id` out X_ID_WIDTH: result ID.
- `result_data` out FLEN: result data.
- `result_rd` out 5: result destination register.
- `orphan` out 1: one-cycle pulse when a completion matches no live slot.
- `count` out $clog2(DEPTH)+1: number of occupied slots.

## Operation
- Storage: circular buffer with head and tail pointers, each $clog2(DEPTH)+1 bits including a wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal.
- Each slot holds: `id`, `data`, `rd`, a state (FREE, ISSUED, COMMITTED, KILLED), and a `done` flag. `done` is independent of state.
- Alloc:
  - Accepted when `alloc_valid && alloc_ready`.
  - The tail slot becomes ISSUED with `done`=0, and the tail advances.
- Commit:
  - Search is associative over non-FREE slots. Match on an ISSUED slot moves it to COMMITTED, or to KILLED if `commit_kill`=1.
  - No match: ignored.
  - Decisions on a COMMITTED or KILLED slot: ignored.
- Completion:
  - Search is associative over slots in ISSUED or COMMITTED with `done`=0.
  - Match: store `data` and `rd`, and set `done`.
  - Match on a KILLED slot: data is dropped, with no `orphan` pulse.
  - No match: data is dropped and `orphan` pulses.
- Retire at head, at most one slot per cycle:
  - KILLED: freed unconditionally.
  - COMMITTED with `done`: drives `result_*`; freed on `result_valid && result_ready`.
  - Otherwise: wait.
- ID uniqueness among live slots is guaranteed by the XIF protocol. If it is violated, the lowest slot index wins.
- Simultaneous events in the same cycle:
  - Alloc + retire: both happen; `count` is unchanged.
  - Alloc + commit for the same ID: the commit applies to the new slot.
  - Commit + completion for the same slot: both apply.
  - Kill + completion for the same slot: slot becomes KILLED and data is dropped.
- Reset mid-operation clears every slot immediately. In-flight results are lost.

## Timing
- Values during and after reset:
  - `alloc_ready`=1, `dp_ready`=1.
  - `result_valid`=0, `orphan`=0, `count`=0.
  - `result_id`, `result_data`, `result_rd`=0.
- `alloc_ready` depends only on the registered `count`. A slot freed in cycle N can be allocated in cycle N+1.
- `result_*` are combinational from the head slot's registers.
- Latency for a completion at edge N on a committed head slot: `result_valid` is 1 in cycle N+1.
- Once asserted, `result_valid` and the payload hold stable until `result_ready`.
- A KILLED head costs one cycle. Back-to-back kills retire at one per cycle.
- `orphan` is registered and asserts the cycle after the completion.

## Configuration
- `RVFPM_RSEQ_BYPASS_EN` defined:
  - A completion whose ID matches a COMMITTED head slot drives `result_*` in the same cycle.
  - If `result_ready`=1 in that cycle, the slot frees without `done` ever being stored. Latency is 0.
  - Payload stability is unaffected: if `result_ready`=0, the data is registered and held.
- `RVFPM_RSEQ_BYPASS_EN` undefined: latency is 1 cycle, as described under Timing.

## Structure
- Package `pa_rvfpm` holds:
  - enum `rseq_state_t` (FREE, ISSUED, COMMITTED, KILLED);
  - struct `rseq_slot_t` (state, done, id, data, rd);
  - constant `RSEQ_PTR_W`.
- Sub-module `rvfpm_rseq_cam`: combinational ID match over DEPTH slots with a state mask. Returns hit plus the lowest matching index. It is instantiated twice: once for commit, once for completion.

## Test plan
- Alloc IDs 1, 2, 3. Complete 3, 2, 1. Commit 1, 2, 3. Expect results in ID order 1, 2, 3, each one cycle after its prerequisites.
- Alloc IDs 5 and 6. Kill 5, commit 6, complete 6 with data 0x3F800000 and rd 4. Expect exactly one result: `id`=6, `data`=0x3F800000, `rd`=4. Slot 5 frees silently.
- Fill DEPTH=4: `alloc_ready`=0 and `count`=4. Retire the head with `result_ready` tied low for 3 cycles, then high. Check payload stability, then that `alloc_ready` rises the cycle after the retire.
- Completion with unknown ID 9 → `orphan` pulses for one cycle and no state changes. Completion for a killed ID → no pulse and no result.
- Alloc, commit and complete ID 7, then assert reset mid-stream → `result_valid`=0 and `count`=0 immediately. After release, ID 7 can be allocated fresh.
- Wrap-around: 10 sequential alloc/commit/complete rounds with DEPTH=4 → all 10 results in order, none lost.
